// File: rtl/vp_op_sequencer_pkg.sv
// Shared definitions for the vector-op sequencer: instruction field layout,
// op encodings and the element-sequencing state enum.
package vp_op_sequencer_pkg;

  localparam int INSTR_W   = 20;
  localparam int OP_LSB    = 17;
  localparam int RA1_LSB   = 15;
  localparam int RA2_LSB   = 13;
  localparam int MADDR_LSB = 4;
  localparam int REP_LSB   = 0;
  localparam int OP_W      = 3;
  localparam int RA_W      = 2;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_MUL = 3'b001;
  localparam logic [OP_W-1:0] OP_ST  = 3'b010;
  localparam logic [OP_W-1:0] OP_LD  = 3'b011;
  localparam logic [OP_W-1:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // Ops 100..111 have no datapath meaning and are dropped at pop time.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return !op[OP_W-1];
  endfunction

endpackage

// File: rtl/vp_op_sequencer_if.sv
// Instruction handshake into the sequencer.
// A word transfers on a rising clk edge where instr_valid && instr_ready are both high;
// the master holds instr_data stable while instr_valid is high and not yet accepted.
interface vp_op_sequencer_if;
  logic                                     instr_valid;
  logic                                     instr_ready;
  logic [vp_op_sequencer_pkg::INSTR_W-1:0]  instr_data;

  modport master (output instr_valid, output instr_data, input  instr_ready);
  modport slave  (input  instr_valid, input  instr_data, output instr_ready);
endinterface

// File: rtl/vp_op_sequencer_instr_fifo.sv
// Synchronous instruction buffer; pointers carry one extra wrap bit so full and
// empty are distinguished without an occupancy counter.
module vp_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/vp_op_sequencer.sv
// Expands buffered vector instructions into 1..16 element operations, each held
// for a fixed ISSUE/COMMIT/DRAIN window so datapath writeback sees stable operands.
module vp_op_sequencer
  import vp_op_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 9,
  parameter int REP_W      = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  vp_op_sequencer_if.slave   instr,
  output logic [OP_W-1:0]    cpu_op,
  output logic [RA_W-1:0]    cpu_reg_wr_addr,
  output logic [RA_W-1:0]    cpu_reg_rd_addr1,
  output logic [RA_W-1:0]    cpu_reg_rd_addr2,
  output logic [ADDR_W-1:0]  cpu_mem_addr,
  output logic               busy,
  output logic               done,
  output logic               err_illegal,
  output logic [CNT_W-1:0]   retired_cnt,
  output state_t             dbg_state
);

  state_t               state;
  logic [OP_W-1:0]      op_q;
  logic [REP_W-1:0]     rep_q;
  logic [REP_W-1:0]     elem_cnt;

  logic [INSTR_W-1:0]   fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 last_elem;

  logic [OP_W-1:0]      f_op;
  logic [RA_W-1:0]      f_ra1;
  logic [RA_W-1:0]      f_ra2;
  logic [ADDR_W-1:0]    f_maddr;
  logic [REP_W-1:0]     f_rep;

  assign f_op    = fifo_dout[OP_LSB    +: OP_W];
  assign f_ra1   = fifo_dout[RA1_LSB   +: RA_W];
  assign f_ra2   = fifo_dout[RA2_LSB   +: RA_W];
  assign f_maddr = fifo_dout[MADDR_LSB +: ADDR_W];
  assign f_rep   = fifo_dout[REP_LSB   +: REP_W];

  assign instr.instr_ready = !fifo_full;
  assign push              = instr.instr_valid && !fifo_full;
  assign last_elem         = (elem_cnt == rep_q);
  assign busy              = (state != ST_IDLE) || !fifo_empty;
  assign dbg_state         = state;

  // Pop from IDLE, or straight out of the final DRAIN so back-to-back work has no bubble.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state == ST_IDLE)                pop = 1'b1;
      if (state == ST_DRAIN && last_elem)  pop = 1'b1;
    end
  end

  vp_instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (instr.instr_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      op_q             <= OP_NOP;
      rep_q            <= '0;
      elem_cnt         <= '0;
      cpu_op           <= OP_NOP;
      cpu_reg_wr_addr  <= '0;
      cpu_reg_rd_addr1 <= '0;
      cpu_reg_rd_addr2 <= '0;
      cpu_mem_addr     <= '0;
      done             <= 1'b0;
      err_illegal      <= 1'b0;
      retired_cnt      <= '0;
    end else begin
      done        <= 1'b0;
      err_illegal <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (pop) state <= op_legal(f_op) ? ST_ISSUE : ST_IDLE;
        end
        ST_ISSUE: begin
          state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          state  <= ST_DRAIN;
          cpu_op <= OP_NOP;
        end
        ST_DRAIN: begin
          if (!last_elem) begin
            elem_cnt     <= elem_cnt + REP_W'(1);
            cpu_mem_addr <= cpu_mem_addr + ADDR_W'(1);
            cpu_op       <= op_q;
            state        <= ST_ISSUE;
          end else begin
            done        <= 1'b1;
            retired_cnt <= retired_cnt + CNT_W'(1);
            state       <= (pop && op_legal(f_op)) ? ST_ISSUE : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Register fields are latched once per instruction; only the memory address steps.
      if (pop) begin
        elem_cnt <= '0;
        if (op_legal(f_op)) begin
          op_q             <= f_op;
          rep_q            <= f_rep;
          cpu_op           <= f_op;
          cpu_reg_rd_addr1 <= f_ra1;
          cpu_reg_rd_addr2 <= f_ra2;
          cpu_reg_wr_addr  <= (f_op == OP_LD) ? f_ra1 : '0;
          cpu_mem_addr     <= f_maddr;
        end else begin
          err_illegal <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vp_op_sequencer.sv
// Directed bench for vp_op_sequencer: an instruction-level model predicts every
// output each cycle, and per-test literal checks pin the expected timing and order.
module tb_vp_op_sequencer;
  import vp_op_sequencer_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  vp_op_sequencer_if ifc ();
  logic [2:0]  cpu_op;
  logic [1:0]  wr_addr, rd_addr1, rd_addr2;
  logic [8:0]  mem_addr;
  logic        busy, done, err_illegal;
  logic [15:0] retired_cnt;
  state_t      dbg_state;

  vp_op_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .instr            (ifc),
    .cpu_op           (cpu_op),
    .cpu_reg_wr_addr  (wr_addr),
    .cpu_reg_rd_addr1 (rd_addr1),
    .cpu_reg_rd_addr2 (rd_addr2),
    .cpu_mem_addr     (mem_addr),
    .busy             (busy),
    .done             (done),
    .err_illegal      (err_illegal),
    .retired_cnt      (retired_cnt),
    .dbg_state        (dbg_state)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [19:0] mk(input logic [2:0] op, input logic [1:0] ra1,
                                      input logic [1:0] ra2, input logic [8:0] ma,
                                      input logic [3:0] rep);
    return {op, ra1, ra2, ma, rep};
  endfunction

  // ---------------- instruction-level model ----------------
  // The active instruction is tracked as a phase count over its 3*(rep+1) cycles:
  // phase%3 is 0/1 while the op is on the bus, phase/3 is the element index.
  logic [19:0] mq[$];
  bit          m_active = 0;
  logic [19:0] m_cur    = '0;
  int          m_ph     = 0;
  logic [1:0]  e_wr = 0, e_rd1 = 0, e_rd2 = 0;
  logic [8:0]  e_mem = 0;
  bit          e_done = 0, e_err = 0;
  logic [15:0] e_ret = 0;

  always @(posedge clk) begin : model_p
    logic [19:0] w;
    bit          acc;
    int          last;
    if (rst) begin
      mq.delete();
      m_active = 0; m_ph = 0; m_cur = '0;
      e_done = 0; e_err = 0; e_ret = 0;
      e_wr = 0; e_rd1 = 0; e_rd2 = 0; e_mem = 0;
    end else begin
      acc    = ifc.instr_valid && (mq.size() < DEPTH);
      e_done = 0;
      e_err  = 0;
      if (m_active) begin
        last = 3 * (int'(m_cur[3:0]) + 1) - 1;
        if (m_ph == last) begin
          e_done   = 1;
          e_ret    = e_ret + 16'd1;
          m_active = 0;
        end else begin
          m_ph++;
        end
      end
      if (!m_active && mq.size() > 0) begin
        w = mq.pop_front();
        if (w[19] == 1'b0) begin
          m_active = 1; m_cur = w; m_ph = 0;
        end else begin
          e_err = 1;
        end
      end
      if (acc) mq.push_back(ifc.instr_data);
      if (m_active) begin
        e_rd1 = m_cur[16:15];
        e_rd2 = m_cur[14:13];
        e_wr  = (m_cur[19:17] == OP_LD) ? m_cur[16:15] : 2'd0;
        e_mem = 9'((int'(m_cur[12:4]) + m_ph / 3) % 512);
      end
    end
  end

  // ---------------- compare + monitor ----------------
  typedef struct {
    logic [2:0] op;
    logic [8:0] addr;
    logic [1:0] wr;
    int         cyc;
  } el_t;

  el_t        el_q[$];
  int         n_opcyc = 0, n_done = 0, n_err = 0, n_active = 0;
  logic [2:0] prev_op = OP_NOP;

  always @(negedge clk) begin : cmp_p
    logic [2:0] e_op;
    e_op = (m_active && (m_ph % 3) < 2) ? m_cur[19:17] : OP_NOP;
    chk("cpu_op",      cpu_op,      e_op);
    chk("rd_addr1",    rd_addr1,    e_rd1);
    chk("rd_addr2",    rd_addr2,    e_rd2);
    chk("wr_addr",     wr_addr,     e_wr);
    chk("mem_addr",    mem_addr,    e_mem);
    chk("busy",        busy,        m_active || mq.size() > 0);
    chk("ready",       ifc.instr_ready, mq.size() < DEPTH);
    chk("done",        done,        e_done);
    chk("err_illegal", err_illegal, e_err);
    chk("retired_cnt", retired_cnt, e_ret);
    if (cpu_op != OP_NOP && prev_op == OP_NOP)
      el_q.push_back('{op: cpu_op, addr: mem_addr, wr: wr_addr, cyc: cyc});
    if (cpu_op != OP_NOP)       n_opcyc++;
    if (done)                   n_done++;
    if (err_illegal)            n_err++;
    if (dbg_state != ST_IDLE)   n_active++;
    prev_op = cpu_op;
  end

  // ---------------- driver tasks ----------------
  int push_cyc = 0;

  task automatic clear_stats();
    el_q.delete();
    n_opcyc = 0; n_done = 0; n_err = 0; n_active = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic push(input logic [19:0] w);
    int i;
    ifc.instr_valid = 1'b1;
    ifc.instr_data  = w;
    i = 0;
    while (!ifc.instr_ready && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk("push_accept", ifc.instr_ready, 1'b1);
    @(negedge clk);
    push_cyc        = cyc;
    ifc.instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((busy || m_active || mq.size() > 0) && i < 500) begin
      @(negedge clk);
      i++;
    end
    chk("idle_timeout", i < 500, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] exp_q[$];

  initial begin
    ifc.instr_valid = 1'b0;
    ifc.instr_data  = '0;
    @(negedge clk);
    do_reset();

    // reset state
    chk("rst_cpu_op", cpu_op, 3'b111);
    chk("rst_ready", ifc.instr_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_retired", retired_cnt, 0);

    // 1: single add, rep=0
    push(mk(OP_ADD, 2'd1, 2'd2, 9'd5, 4'd0));
    wait_idle();
    chk("t1_op_cycles", n_opcyc, 2);
    chk("t1_elems", el_q.size(), 1);
    if (el_q.size() > 0) begin
      chk("t1_latency_edges", el_q[0].cyc - push_cyc, 1);
      chk("t1_op", el_q[0].op, OP_ADD);
    end
    chk("t1_done", n_done, 1);
    chk("t1_retired", retired_cnt, 1);

    // 2: store with address wrap 510,511,0,1
    do_reset();
    push(mk(OP_ST, 2'd3, 2'd0, 9'd510, 4'd3));
    wait_idle();
    exp_q = '{510, 511, 0, 1};
    chk("t2_elems", el_q.size(), 4);
    for (int i = 0; i < 4 && i < el_q.size(); i++) begin
      chk("t2_addr", el_q[i].addr, exp_q[i]);
      if (i > 0) chk("t2_spacing", el_q[i].cyc - el_q[i-1].cyc, 3);
    end
    chk("t2_op_cycles", n_opcyc, 8);
    chk("t2_done", n_done, 1);
    chk("t2_active_cycles", n_active, 12);

    // 3: fill the buffer behind a long instruction
    do_reset();
    push(mk(OP_ST,  2'd1, 2'd2, 9'd20, 4'd15));
    push(mk(OP_ADD, 2'd0, 2'd1, 9'd0,  4'd0));
    push(mk(OP_MUL, 2'd1, 2'd1, 9'd1,  4'd1));
    push(mk(OP_LD,  2'd3, 2'd0, 9'd2,  4'd0));
    push(mk(OP_ADD, 2'd2, 2'd3, 9'd3,  4'd0));
    chk("t3_full_ready", ifc.instr_ready, 1'b0);
    push(mk(OP_MUL, 2'd0, 2'd0, 9'd4,  4'd0));
    wait_idle();
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(OP_ST));
    exp_q.push_back(32'(OP_ADD));
    exp_q.push_back(32'(OP_MUL));
    exp_q.push_back(32'(OP_MUL));
    exp_q.push_back(32'(OP_LD));
    exp_q.push_back(32'(OP_ADD));
    exp_q.push_back(32'(OP_MUL));
    chk("t3_elems", el_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < el_q.size(); i++)
      chk("t3_order", el_q[i].op, exp_q[i]);
    chk("t3_retired", retired_cnt, 6);

    // 4: load then mul, no idle bubble between them
    clear_stats();
    push(mk(OP_LD,  2'd2, 2'd1, 9'd100, 4'd1));
    push(mk(OP_MUL, 2'd0, 2'd3, 9'd7,   4'd0));
    wait_idle();
    chk("t4_elems", el_q.size(), 3);
    if (el_q.size() == 3) begin
      chk("t4_ld0_wr", el_q[0].wr, 2);
      chk("t4_ld1_wr", el_q[1].wr, 2);
      chk("t4_ld1_addr", el_q[1].addr, 101);
      chk("t4_mul_op", el_q[2].op, OP_MUL);
      chk("t4_mul_wr", el_q[2].wr, 0);
      chk("t4_handoff", el_q[2].cyc - el_q[1].cyc, 3);
    end

    // 5: illegal op from IDLE, then a normal add
    do_reset();
    push(mk(3'b101, 2'd1, 2'd1, 9'd9,  4'd2));
    push(mk(OP_ADD, 2'd1, 2'd0, 9'd50, 4'd0));
    wait_idle();
    chk("t5_err", n_err, 1);
    chk("t5_done", n_done, 1);
    chk("t5_retired", retired_cnt, 1);
    chk("t5_elems", el_q.size(), 1);
    if (el_q.size() > 0) chk("t5_op", el_q[0].op, OP_ADD);

    // 5b: illegal op popped at the DRAIN handoff
    clear_stats();
    push(mk(OP_LD,  2'd1, 2'd0, 9'd8, 4'd0));
    push(mk(3'b110, 2'd0, 2'd0, 9'd0, 4'd0));
    wait_idle();
    chk("t5b_err", n_err, 1);
    chk("t5b_done", n_done, 1);
    chk("t5b_retired", retired_cnt, 2);
    chk("t5b_active", n_active, 3);

    // 6: reset during COMMIT of a long store
    do_reset();
    push(mk(OP_ST, 2'd1, 2'd2, 9'd30, 4'd7));
    begin
      int i;
      i = 0;
      while (dbg_state != ST_COMMIT && i < 50) begin
        @(negedge clk);
        i++;
      end
      chk("t6_reach_commit", dbg_state, ST_COMMIT);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("t6_cpu_op", cpu_op, 3'b111);
    chk("t6_busy", busy, 1'b0);
    chk("t6_ready", ifc.instr_ready, 1'b1);
    chk("t6_done", done, 1'b0);
    chk("t6_retired", retired_cnt, 0);
    rst = 1'b0;
    clear_stats();
    repeat (30) @(negedge clk);
    chk("t6_no_done", n_done, 0);
    chk("t6_no_ops", n_opcyc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
